sync_debounce: RTL

- Single-clock, per-bit debounce and edge-detect stage.
- Sits directly downstream of the synchroniser: consumes its synchronised level output (dat_o).
- Per bit, it commits a new level only after the input has held that level for a programmable number of cycles.
- It then raises one-cycle rise/fall pulses, plus an any-change pulse for interrupt logic.

---
 rtl/sync_debounce_pkg.sv | 12 +
 rtl/sync_debounce_bit.sv | 90 +++++++++
 rtl/sync_debounce.sv | 53 +++++
 3 files changed

// File: rtl/sync_debounce_pkg.sv
// Shared types and defaults for the per-bit debounce stage.
// The state encoding is fixed so that the idle state is the reset value of the state flop.
package sync_debounce_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } deb_state_t;

  localparam int DEFAULT_CNT_WIDTH = 16;

endpackage

// File: rtl/sync_debounce_bit.sv
// One debounced bit: a stability FSM plus counter, the committed level and its rise/fall pulses.
// commit_o is the combinational commit decision, so the parent can register an aligned change flag.
module sync_debounce_bit
  import sync_debounce_pkg::*;
#(
  parameter int   CNT_WIDTH = DEFAULT_CNT_WIDTH,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [CNT_WIDTH-1:0] thr_i,
  input  logic                 dat_i,
  output logic                 dat_o,
  output logic                 rise_o,
  output logic                 fall_o,
  output logic                 commit_o
);

  deb_state_t           state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg, cnt_next;
  logic                 dat_reg, rise_reg, fall_reg;
  logic                 commit;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    if (!en_i) begin
      state_next = STABLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        STABLE: begin
          if (dat_i == dat_reg) begin
            cnt_next = '0;
          end else if (thr_i <= CNT_WIDTH'(1)) begin
            commit = 1'b1;
          end else begin
            state_next = CHECK;
            cnt_next   = CNT_WIDTH'(1);
          end
        end
        CHECK: begin
          if (dat_i == dat_reg) begin
            state_next = STABLE;
            cnt_next   = '0;
          end else if (cnt_reg >= thr_i) begin
            // Also covers a threshold lowered below the running count mid-check.
            commit = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_WIDTH'(1);
          end
        end
        default: begin
          state_next = STABLE;
          cnt_next   = '0;
        end
      endcase
      if (commit) begin
        state_next = STABLE;
        cnt_next   = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg <= STABLE;
      cnt_reg   <= '0;
      dat_reg   <= RST_VAL;
      rise_reg  <= 1'b0;
      fall_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (commit) begin
        dat_reg <= dat_i;
      end
      rise_reg <= commit & dat_i;
      fall_reg <= commit & ~dat_i;
    end
  end

  assign dat_o    = dat_reg;
  assign rise_o   = rise_reg;
  assign fall_o   = fall_reg;
  assign commit_o = commit;

endmodule

// File: rtl/sync_debounce.sv
// Per-bit debounce and edge detect for a synchronised bus, with one any-change pulse.
// chg_o is registered from the same commit decisions as rise_o/fall_o so all pulses line up.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int                    DATA_WIDTH = 1,
  parameter int                    CNT_WIDTH  = DEFAULT_CNT_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RST_VAL    = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [CNT_WIDTH-1:0]  thr_i,
  input  logic [DATA_WIDTH-1:0] dat_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic [DATA_WIDTH-1:0] rise_o,
  output logic [DATA_WIDTH-1:0] fall_o,
  output logic                  chg_o
);

  logic [DATA_WIDTH-1:0] commit_vec;
  logic                  chg_reg;

  generate
    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_bit
      sync_debounce_bit #(
        .CNT_WIDTH (CNT_WIDTH),
        .RST_VAL   (RST_VAL[gi])
      ) u_bit (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .en_i     (en_i),
        .thr_i    (thr_i),
        .dat_i    (dat_i[gi]),
        .dat_o    (dat_o[gi]),
        .rise_o   (rise_o[gi]),
        .fall_o   (fall_o[gi]),
        .commit_o (commit_vec[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      chg_reg <= 1'b0;
    end else begin
      chg_reg <= |commit_vec;
    end
  end

  assign chg_o = chg_reg;

endmodule
